// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encodings, round count,
// round-index width, S-box table and the per-round byte transforms.
package aes_pkg;

  localparam int NR     = 10;
  localparam int RIDX_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte (r,c) lives at index r+4c counted from the MSB end.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// One AES round, purely combinational; final_round skips MixColumns.
module aes_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk_in,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [127:0] shifted;
  logic [127:0] mixed;

  assign shifted    = shift_rows(sub_bytes(state));
  assign mixed      = final_round ? shifted : mix_columns(shifted);
  assign next_state = mixed ^ rk_in;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer, one round per clock.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for a plaintext block, initial AddRoundKey on accept
// ROUND | full rounds 1..NR-1, rk_idx = round_q
// FINAL | last round without MixColumns, rk_idx = NR
// DONE  | ciphertext presented until out_ready
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [RIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  logic [1:0]        fsm_q, fsm_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [127:0]      state_q, state_d;
  logic [127:0]      dp_next;

  aes_round_datapath u_dp (
    .state       (state_q),
    .rk_in       (rk_in),
    .final_round (fsm_q == ST_FINAL),
    .next_state  (dp_next)
  );

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        round_d = '0;
        if (in_valid) begin
          state_d = in_data ^ rk_in;
          round_d = RIDX_W'(1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = dp_next;
        round_d = round_q + RIDX_W'(1);
        if (round_q == RIDX_W'(NR - 1)) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        state_d = dp_next;
        fsm_d   = ST_DONE;
      end
      default: begin
        if (out_ready) begin
          fsm_d   = ST_IDLE;
          round_d = '0;
        end
      end
    endcase
`ifdef AES_CTRL_ABORT_EN
    // Abort wins over out_ready so a cancelled block is never handed over.
    if (abort && (fsm_q != ST_IDLE)) begin
      fsm_d   = ST_IDLE;
      round_d = '0;
      state_d = state_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    rk_idx = '0;
    case (fsm_q)
      ST_ROUND: rk_idx = round_q;
      ST_FINAL: rk_idx = RIDX_W'(NR);
      default:  rk_idx = '0;
    endcase
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign busy      = (fsm_q != ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  // Intermediate round states are not exposed on the output bus.
  assign out_data  = out_valid ? state_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with an independent AES-128 model
// (S-box derived from GF(2^8) inversion) and an in-order ciphertext scoreboard.
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FIPS_S0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] PT_A    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT_B    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PT_C    = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] PT_D    = 128'hf69f2445df4f9b17ad2b417be66c3710;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] rk_in, out_data;
  logic [3:0]   rk_idx;
`ifdef AES_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  logic [7:0]   sb [256];
  logic [127:0] rk_tab [16];
  assign rk_in = rk_tab[rk_idx];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_xfer = 0;
  logic [127:0] exp_q [$];
  int acc_cyc [$];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
    int           stall;
  } vec_t;
  vec_t vecs [5];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] bb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      bb = {inv, inv};
      sb[x] = inv ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]] ^ rc, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[rnd][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Inputs are already set; log what the coming edge does, then advance.
  task automatic tick();
    logic [127:0] e;
    logic         xfer;
    chk("ready_valid_excl", {127'd0, in_ready & out_valid}, 128'd0);
    xfer = out_valid && out_ready;
`ifdef AES_CTRL_ABORT_EN
    xfer = xfer && !abort;
`endif
    if (in_valid && in_ready) begin
      exp_q.push_back(model_enc(in_data));
      acc_cyc.push_back(cyc);
    end
    if (xfer) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_extra: got ciphertext %h, want none pending", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard_ct", out_data, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_one(input logic [127:0] pt, input logic [127:0] ct,
                         input int stall, input string tag);
    int lat;
    lat = 0;
    while (!in_ready && lat < 30) begin tick(); lat++; end
    chk({tag, "_ready"}, {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = pt;
    tick();
    in_valid = 1'b0;
    in_data  = rnd128();
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_ct"}, out_data, ct);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = rnd128();
      tick();
      chk({tag, "_stall_data"}, out_data, ct);
      chk({tag, "_stall_busy"}, {126'd0, in_ready, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_idle_after"}, {125'd0, in_ready, busy, out_valid}, 128'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int x0;
    build_sbox();
    expand_key(KEY);

    vecs[0] = '{FIPS_PT, FIPS_CT, 0};
    vecs[1] = '{128'd0, model_enc(128'd0), 3};
    vecs[2] = '{{128{1'b1}}, model_enc({128{1'b1}}), 0};
    vecs[3] = '{PT_A, model_enc(PT_A), 1};
    vecs[4] = '{PT_D, model_enc(PT_D), 20};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_rk_idx", {124'd0, rk_idx}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 Appendix B with intermediate state and key index walk
    in_valid = 1'b1;
    in_data  = FIPS_PT;
    tick();
    in_valid = 1'b0;
    in_data  = rnd128();
    chk("state_after_accept", dut.state_q, FIPS_S0);
    for (int k = 1; k <= 10; k++) begin
      chk("rk_idx_step", {124'd0, rk_idx}, 128'(k));
      chk("no_early_valid", {127'd0, out_valid}, 128'd0);
      tick();
    end
    chk("fips_valid_at_10", {127'd0, out_valid}, 128'd1);
    chk("fips_ct", out_data, FIPS_CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fips_idle", {127'd0, in_ready}, 128'd1);

    // table-driven blocks, last one with 20 cycles of backpressure
    for (int i = 0; i < 5; i++) run_one(vecs[i].pt, vecs[i].ct, vecs[i].stall, $sformatf("vec%0d", i));

    // back-to-back with in_valid held high
    base = acc_cyc.size();
    x0 = n_xfer;
    in_valid  = 1'b1;
    in_data   = PT_B;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (n_xfer - x0) < 2; i++) begin
      tick();
      if (acc_cyc.size() - base == 1) in_data = PT_C;
      else if (acc_cyc.size() - base >= 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 128'(acc_cyc.size() - base), 128'd2);
    chk("b2b_transfers", 128'(n_xfer - x0), 128'd2);
    if (acc_cyc.size() - base >= 2)
      chk("b2b_spacing", 128'(acc_cyc[base+1] - acc_cyc[base]), 128'd12);

    // reset in round 5, then a clean block
    in_valid = 1'b1;
    in_data  = PT_C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && rk_idx != 4'd5; i++) tick();
    chk("rst_mid_round5", {124'd0, rk_idx}, 128'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {124'd0, in_ready, out_valid, busy, 1'b0}, 128'h8);
    chk("rst_mid_rk_idx", {124'd0, rk_idx}, 128'd0);
    chk("rst_mid_out_data", out_data, 128'd0);
    chk("rst_mid_state_q", dut.state_q, 128'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(PT_B, model_enc(PT_B), 2, "post_rst");

`ifdef AES_CTRL_ABORT_EN
    in_valid = 1'b1;
    in_data  = PT_A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && rk_idx != 4'd3; i++) tick();
    chk("abort_r3_reached", {124'd0, rk_idx}, 128'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_r3_idle", {125'd0, in_ready, busy, out_valid}, 128'd4);
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = PT_D;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("abort_done_reached", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_done_idle", {125'd0, in_ready, busy, out_valid}, 128'd4);
    exp_q.delete();
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = PT_A;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_idle_no_effect", {127'd0, busy}, 128'd1);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    chk("scoreboard_drain", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
